// File: rtl/psd_pkg.sv
// Shared types and constants for the psdsquare squarer and its rounding stage.
package psd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NBITSIN_DEF = 32;
    localparam int RBITS_DEF   = 8;

    // Half-to-even threshold: guard is the top discarded bit (weight one half),
    // sticky is any lower discarded bit; a bare guard is an exact tie.
    function automatic logic round_up(input logic guard, input logic sticky, input logic lsb);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/psd_round_half_even.sv
// Combinational round-half-to-even of value / 2^RBITS, result zero-extended to WIDTH bits.
module psd_round_half_even
    import psd_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int RBITS = RBITS_DEF
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] rounded
);

    logic [WIDTH-RBITS-1:0] kept;
    logic                   guard;
    logic                   sticky;
    logic                   up;

    assign kept  = value[WIDTH-1:RBITS];
    assign guard = value[RBITS-1];

    generate
        if (RBITS > 1) begin : g_sticky
            assign sticky = |value[RBITS-2:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end
    endgenerate

    assign up = round_up(guard, sticky, kept[0]);

    // Upper RBITS bits are zero, so the increment carry always has room.
    assign rounded = {{RBITS{1'b0}}, kept} + {{(WIDTH-1){1'b0}}, up};

endmodule

// File: rtl/psdsquare.sv
// Sequential shift-add squarer: one multiplier bit per clock, start/busy/done handshake.
// Define PSDSQUARE_ROUND_EN to round the product half-to-even by RBITS bits.
module psdsquare
    import psd_pkg::*;
#(
    parameter int NBITSIN = NBITSIN_DEF,
    parameter int RBITS   = RBITS_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NBITSIN-1:0]     xin,
    output logic                   busy,
    output logic                   done,
    output logic [2*NBITSIN-1:0]   sq
);

    localparam int PW = 2 * NBITSIN;
    localparam int CW = $clog2(NBITSIN);

    generate
        if (NBITSIN < 2 || NBITSIN > 32 || RBITS < 1 || RBITS > 2*NBITSIN-2) begin : g_param_check
            $error("psdsquare: NBITSIN or RBITS out of range");
        end
    endgenerate

    state_t              state_reg, state_next;
    logic [PW-1:0]       acc_reg, acc_next;
    logic [PW-1:0]       mcand_reg, mcand_next;
    logic [NBITSIN-1:0]  mplier_reg, mplier_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [PW-1:0]       sq_reg, sq_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic [PW-1:0]       acc_sum;
    logic [PW-1:0]       sq_final;
    logic                last_iter;
    logic                load;

    assign acc_sum   = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;
    assign last_iter = (cnt_reg == CW'(NBITSIN - 1));
    // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
    assign load      = start && (state_reg != BUSY);

`ifdef PSDSQUARE_ROUND_EN
    psd_round_half_even #(
        .WIDTH (PW),
        .RBITS (RBITS)
    ) u_round (
        .value   (acc_sum),
        .rounded (sq_final)
    );
`else
    assign sq_final = acc_sum;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    state_next = start ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_next   = (state_next == BUSY);
        done_next   = (state_next == DONE);
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        sq_next     = sq_reg;
        if (load) begin
            acc_next    = '0;
            mcand_next  = {{NBITSIN{1'b0}}, xin};
            mplier_next = xin;
            cnt_next    = '0;
        end else if (state_reg == BUSY) begin
            acc_next    = acc_sum;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + CW'(1);
            if (last_iter) sq_next = sq_final;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            sq_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            sq_reg     <= sq_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sq   = sq_reg;

endmodule

// File: tb/tb_psdsquare.sv
// Directed-vector bench for psdsquare; also covers the PSDSQUARE_ROUND_EN build (NBITSIN=16, RBITS=8).
module tb_psdsquare;

`ifdef PSDSQUARE_ROUND_EN
    localparam int NB = 16;
`else
    localparam int NB = 32;
`endif
    localparam int RB = 8;
    localparam int PW = 2 * NB;

    logic          clock;
    logic          reset;
    logic          start;
    logic [NB-1:0] xin;
    logic          busy;
    logic          done;
    logic [PW-1:0] sq;

    int n_checks    = 0;
    int n_pass      = 0;
    int overlap_cnt = 0;

    psdsquare #(
        .NBITSIN (NB),
        .RBITS   (RB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .xin   (xin),
        .busy  (busy),
        .done  (done),
        .sq    (sq)
    );

`ifdef PSDSQUARE_ROUND_EN
    logic [15:0] rnd_in;
    logic [15:0] rnd_out;
    psd_round_half_even #(
        .WIDTH (16),
        .RBITS (8)
    ) u_rnd (
        .value   (rnd_in),
        .rounded (rnd_out)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done && busy) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic logic [63:0] ref_sq(input logic [NB-1:0] x);
        logic [63:0] p;
        p = 64'(x) * 64'(x);
`ifdef PSDSQUARE_ROUND_EN
        begin
            logic [63:0] q, r, h;
            q = p >> RB;
            r = p & ((64'd1 << RB) - 64'd1);
            h = 64'd1 << (RB - 1);
            if (r > h || (r == h && q[0])) q = q + 64'd1;
            p = q;
        end
`endif
        return p;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [NB-1:0] x, output int lat);
        start = 1'b1;
        xin   = x;
        lat   = 0;
        do begin
            @(negedge clock);
            lat++;
            start = 1'b0;
        end while (!done && lat < 200);
        if (!done) check("done_timeout", 64'(lat), 64'(NB + 1));
        $display("op xin=%0d sq=%0d latency=%0d", x, sq, lat);
    endtask

    initial begin
        int lat;
        int dones;
        logic [NB-1:0] x;

        reset = 1'b1;
        start = 1'b0;
        xin   = '0;
        repeat (2) @(negedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sq", 64'(sq), 64'd0);
        reset = 1'b0;
        @(negedge clock);

`ifndef PSDSQUARE_ROUND_EN
        run_op(32'd0, lat);
        check("lat_zero", 64'(lat), 64'd33);
        check("sq_zero", 64'(sq), 64'd0);
        run_op(32'd1, lat);
        check("sq_one", 64'(sq), 64'd1);
        run_op(32'd65535, lat);
        check("sq_65535", 64'(sq), 64'd4294836225);
        run_op(32'hFFFF_FFFF, lat);
        check("sq_max", 64'(sq), 64'hFFFF_FFFE_0000_0001);
        check("lat_max", 64'(lat), 64'd33);
        @(negedge clock);
        check("done_one_cycle", 64'(done), 64'd0);
        check("sq_hold", 64'(sq), 64'hFFFF_FFFE_0000_0001);

        run_op(32'd3, lat);
        check("b2b_first", 64'(sq), 64'd9);
        run_op(32'd5, lat);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_second", 64'(sq), 64'd25);
`else
        run_op(16'd16, lat);
        check("rnd_16", 64'(sq), 64'd1);
        check("rnd_lat", 64'(lat), 64'd17);
        run_op(16'd23, lat);
        check("rnd_23", 64'(sq), 64'd2);
        run_op(16'd27, lat);
        check("rnd_27", 64'(sq), 64'd3);
        run_op(16'd65535, lat);
        check("rnd_65535", 64'(sq), 64'd16776704);
        rnd_in = 16'h0180; #1 check("tie_odd_up", 64'(rnd_out), 64'd2);
        rnd_in = 16'h0280; #1 check("tie_even_hold", 64'(rnd_out), 64'd2);
        rnd_in = 16'h0181; #1 check("above_half", 64'(rnd_out), 64'd2);
        rnd_in = 16'h017F; #1 check("below_half", 64'(rnd_out), 64'd1);
        @(negedge clock);
`endif

        // A start 10 cycles into an operation must be ignored.
        start = 1'b1;
        xin   = NB'(12);
        lat   = 0;
        dones = 0;
        while (lat < NB + 40) begin
            @(negedge clock);
            lat++;
            start = 1'b0;
            if (lat == 10) begin
                start = 1'b1;
                xin   = NB'(7);
            end
            if (lat == 11) check("ign_busy", 64'(busy), 64'd1);
            if (done) begin
                dones++;
                check("ign_lat", 64'(lat), 64'(NB + 1));
                check("ign_sq", 64'(sq), ref_sq(NB'(12)));
            end
        end
        check("ign_one_done", 64'(dones), 64'd1);

        // Asynchronous reset mid-operation clears outputs before any clock edge.
        start = 1'b1;
        xin   = NB'(1000);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_sq", 64'(sq), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        repeat (NB + 5) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("arst_no_done", 64'(dones), 64'd0);
        run_op(NB'(4), lat);
        check("arst_after", 64'(sq), ref_sq(NB'(4)));
        check("arst_after_16", 64'(sq), (NB == 32) ? 64'd16 : 64'd0);

        for (int i = 0; i < 800; i++) begin
            x = NB'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_op(x, lat);
            check("rand_sq", 64'(sq), ref_sq(x));
            check("rand_lat", 64'(lat), 64'(NB + 1));
        end

        check("done_busy_overlap", 64'(overlap_cnt), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
